// File: rtl/cpu_types_pkg.sv
// Shared CPU datapath types used by the pipeline stages.
package cpu_types_pkg;

    typedef logic [31:0] word_t;
    typedef logic [4:0]  regbits_t;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        HALTED
    } memstate_t;

    localparam regbits_t REG_ZERO = 5'd0;

endpackage

// File: rtl/mem_wait_ctr.sv
// Saturating wait counter for outstanding data-cache requests.
// terminal is high while the count sits at LIMIT.
module mem_wait_ctr #(
    parameter int CNT_W = 7,
    parameter int LIMIT = 64
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic terminal
);

    logic [CNT_W-1:0] count;

    assign terminal = (count == CNT_W'(LIMIT));

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            count <= '0;
        end else if (en && !terminal) begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/mem_stage.sv
// Memory stage: data-cache handshake, MEM/WB latch, forwarding tap,
// stall request and the sticky halt/error flags.
module mem_stage
    import cpu_types_pkg::*;
#(
    parameter int TIMEOUT = 64,
    parameter int CNT_W   = 7
) (
    input  logic     CLK,
    input  logic     RST,
    input  word_t    aluOutport_i,
    input  word_t    rdat2_i,
    input  word_t    pcplus4_i,
    input  regbits_t writeReg_i,
    input  logic     regWEN_i,
    input  logic     MemToReg_i,
    input  logic     JType_i,
    input  logic     dMemREN_i,
    input  logic     dMemWEN_i,
    input  logic     Halt_i,
    input  logic     wb_en_i,
    input  logic     flush_i,
    input  logic     dhit,
    input  word_t    dmemload,
    output logic     dmemREN,
    output logic     dmemWEN,
    output word_t    dmemaddr,
    output word_t    dmemstore,
    output logic     mem_stall_o,
    output logic     fwd_valid_o,
    output regbits_t fwd_reg_o,
    output word_t    fwd_data_o,
    output word_t    wb_wdat_o,
    output regbits_t wb_wsel_o,
    output logic     wb_WEN_o,
    output logic     halt_o,
    output logic     err_o
);

    memstate_t state;
    logic      fresh;
    logic      err_q;
    logic      flush_pend;
    logic      active;
    logic      latch_en;
    logic      apply_flush;
    logic      both_req;
    logic      timeout_hit;
    word_t     wdat_next;

    // fresh blocks requests for the cycle after reset so a dropped access is not reissued immediately
    assign active      = ~fresh & (state != HALTED);
    assign dmemWEN     = active & dMemWEN_i;
    assign dmemREN     = active & dMemREN_i & ~dMemWEN_i;
    assign dmemaddr    = aluOutport_i;
    assign dmemstore   = rdat2_i;
    assign mem_stall_o = (dmemREN | dmemWEN) & ~dhit;
    assign both_req    = active & dMemREN_i & dMemWEN_i;

    assign latch_en    = wb_en_i & active & ~mem_stall_o;
    assign apply_flush = flush_i | flush_pend;

    assign fwd_valid_o = regWEN_i & ~MemToReg_i & (writeReg_i != REG_ZERO);
    assign fwd_reg_o   = writeReg_i;
    assign fwd_data_o  = JType_i ? pcplus4_i : aluOutport_i;

    assign halt_o = (state == HALTED);
    assign err_o  = err_q | timeout_hit;

    always_comb begin
        wdat_next = aluOutport_i;
        if (MemToReg_i) begin
            wdat_next = dmemload;
        end else if (JType_i) begin
            wdat_next = pcplus4_i;
        end
    end

    mem_wait_ctr #(
        .CNT_W(CNT_W),
        .LIMIT(TIMEOUT)
    ) u_wait_ctr (
        .clk     (CLK),
        .rst     (RST),
        .clr     (~mem_stall_o),
        .en      (mem_stall_o),
        .terminal(timeout_hit)
    );

    always_ff @(posedge CLK) begin
        if (RST) begin
            state      <= IDLE;
            fresh      <= 1'b1;
            err_q      <= 1'b0;
            flush_pend <= 1'b0;
            wb_wdat_o  <= '0;
            wb_wsel_o  <= REG_ZERO;
            wb_WEN_o   <= 1'b0;
        end else begin
            fresh <= 1'b0;
            if (timeout_hit || both_req) begin
                err_q <= 1'b1;
            end

            if (state != HALTED) begin
                if (latch_en && !apply_flush && Halt_i) begin
                    state <= HALTED;
                end else if (mem_stall_o) begin
                    state <= WAIT;
                end else begin
                    state <= IDLE;
                end
            end

            // A flush seen during a stall is remembered and applied when the access completes
            if (state == HALTED) begin
                wb_WEN_o   <= 1'b0;
                flush_pend <= 1'b0;
            end else if (latch_en) begin
                flush_pend <= 1'b0;
                if (apply_flush) begin
                    wb_wdat_o <= '0;
                    wb_wsel_o <= REG_ZERO;
                    wb_WEN_o  <= 1'b0;
                end else begin
                    wb_wdat_o <= wdat_next;
                    wb_wsel_o <= writeReg_i;
                    wb_WEN_o  <= regWEN_i;
                end
            end else if (flush_i && mem_stall_o) begin
                flush_pend <= 1'b1;
            end
        end
    end

endmodule
